// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: one request at a time against a 64-bit-word data memory.
// Latency from acceptance: error 1 cycle, load and dword store 2 cycles, sub-dword store 3 cycles (read-modify-write).
// Backpressure: req_ready is low from acceptance until the unit is idle again; the response pulse cannot be stalled.
module mem_access_unit #(
    parameter int MEM_WORDS_LOG2 = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [63:0] resp_rdata,
    output logic        datamem_ena,
    output logic        memwb_ena,
    output logic [63:0] mem_r_addr,
    output logic [63:0] mem_w_addr,
    output logic [63:0] mem_w_data,
    input  logic [63:0] mem_r_data
);

    localparam int RANGE_LSB = MEM_WORDS_LOG2 + 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic        accept;
    logic        misaligned;
    logic        out_of_range;
    logic        req_err;

    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [63:0] addr_q;
    logic        err_q;
    // Holds the store data on acceptance, then the merged word after RD.
    logic [63:0] word_q;
    logic [63:0] rdata_q;

    logic [63:0] word_idx;
    logic [5:0]  shift;
    logic [63:0] size_mask;
    logic [63:0] lane_raw;
    logic [63:0] load_val;
    logic [63:0] merged;

    assign accept = req_valid && req_ready;

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = |req_addr[1:0];
            default: misaligned = |req_addr[2:0];
        endcase
    end

    assign out_of_range = |req_addr[63:RANGE_LSB];
    assign req_err      = misaligned || out_of_range;

    assign word_idx = {3'b000, addr_q[63:3]};
    assign shift    = {addr_q[2:0], 3'b000};

    always_comb begin
        size_mask = 64'h0;
        case (size_q)
            2'd0:    size_mask = 64'h0000_0000_0000_00FF;
            2'd1:    size_mask = 64'h0000_0000_0000_FFFF;
            2'd2:    size_mask = 64'h0000_0000_FFFF_FFFF;
            default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    end

    assign lane_raw = mem_r_data >> shift;

    // Sign source is the MSB of the addressed lane.
    always_comb begin
        load_val = 64'h0;
        case (size_q)
            2'd0:    load_val = uns_q ? {56'h0, lane_raw[7:0]}
                                      : {{56{lane_raw[7]}}, lane_raw[7:0]};
            2'd1:    load_val = uns_q ? {48'h0, lane_raw[15:0]}
                                      : {{48{lane_raw[15]}}, lane_raw[15:0]};
            2'd2:    load_val = uns_q ? {32'h0, lane_raw[31:0]}
                                      : {{32{lane_raw[31]}}, lane_raw[31:0]};
            default: load_val = lane_raw;
        endcase
    end

    assign merged = (mem_r_data & ~(size_mask << shift)) | ((word_q & size_mask) << shift);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        state_nxt = RESP;
                    end else if (req_we && (req_size == 2'd3)) begin
                        state_nxt = WR;
                    end else begin
                        state_nxt = RD;
                    end
                end
            end
            RD:      state_nxt = we_q ? WR : RESP;
            WR:      state_nxt = RESP;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            addr_q  <= 64'h0;
            err_q   <= 1'b0;
            word_q  <= 64'h0;
            rdata_q <= 64'h0;
        end else begin
            if (accept) begin
                we_q   <= req_we;
                size_q <= req_size;
                uns_q  <= req_unsigned;
                addr_q <= req_addr;
                err_q  <= req_err;
                word_q <= req_wdata;
            end
            if ((state == RD) && we_q) begin
                word_q <= merged;
            end
            // resp_rdata only changes on entry to RESP, so it holds between responses.
            if ((state_nxt == RESP) && (state != RESP)) begin
                rdata_q <= ((state == RD) && !we_q) ? load_val : 64'h0;
            end
        end
    end

    // Output logic
    always_comb begin
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_err    = 1'b0;
        datamem_ena = 1'b0;
        memwb_ena   = 1'b0;
        mem_r_addr  = 64'h0;
        mem_w_addr  = 64'h0;
        mem_w_data  = 64'h0;
        case (state)
            IDLE: req_ready = !rst;
            RD: begin
                memwb_ena  = 1'b1;
                mem_r_addr = word_idx;
            end
            WR: begin
                datamem_ena = 1'b1;
                mem_w_addr  = word_idx;
                mem_w_data  = word_q;
            end
            default: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
            end
        endcase
    end

    assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, reset corner cases and a random
// request stream checked against a byte-array reference memory.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [63:0] req_addr = 64'h0;
    logic [63:0] req_wdata = 64'h0;
    logic        resp_valid;
    logic        resp_err;
    logic [63:0] resp_rdata;
    logic        datamem_ena;
    logic        memwb_ena;
    logic [63:0] mem_r_addr;
    logic [63:0] mem_w_addr;
    logic [63:0] mem_w_data;
    logic [63:0] mem_r_data;

    int errors = 0;
    int checks = 0;

    logic [63:0] mem [64];
    logic [7:0]  ref_bytes [512];
    logic [63:0] last_rdata = 64'h0;

    mem_access_unit #(.MEM_WORDS_LOG2(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .resp_rdata   (resp_rdata),
        .datamem_ena  (datamem_ena),
        .memwb_ena    (memwb_ena),
        .mem_r_addr   (mem_r_addr),
        .mem_w_addr   (mem_w_addr),
        .mem_w_data   (mem_w_data),
        .mem_r_data   (mem_r_data)
    );

    always #5 clk = ~clk;

    // Data memory: combinational read, write on the rising edge.
    always @(posedge clk) begin
        if (datamem_ena) mem[mem_w_addr[5:0]] <= mem_w_data;
    end
    assign mem_r_data = memwb_ena ? mem[mem_r_addr[5:0]] : 64'h0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic ref_err(logic [63:0] a, logic [1:0] s);
        int nb = 1 << s;
        return ((a % 64'(nb)) != 0) || (a >= 64'd512);
    endfunction

    function automatic logic [63:0] ref_load(logic [63:0] a, logic [1:0] s, logic u);
        int nb = 1 << s;
        int base = int'(a[8:0]);
        logic [63:0] v = 64'h0;
        for (int i = 0; i < nb; i++) v = v | (64'(ref_bytes[base + i]) << (8 * i));
        if (!u && nb < 8 && v[8 * nb - 1]) v = v | (~64'h0 << (8 * nb));
        return v;
    endfunction

    task automatic ref_store(input logic [63:0] a, input logic [1:0] s, input logic [63:0] d);
        int nb = 1 << s;
        int base = int'(a[8:0]);
        for (int i = 0; i < nb; i++) ref_bytes[base + i] = d[8 * i +: 8];
    endtask

    task automatic do_op(input logic we, input logic [1:0] size, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input logic exp_err, input logic [63:0] exp_rdata, input string tag);
        int lat = 0;
        int rd_cyc = 0;
        int wr_cyc = 0;
        int n_rd = 0;
        int n_wr = 0;
        bit addr_bad = 1'b0;
        bit busy_bad = 1'b0;
        logic got_err = 1'b0;
        logic [63:0] got_rdata = 64'h0;
        int exp_lat;
        int exp_rd;
        int exp_wr;
        exp_lat = exp_err ? 1 : ((we && size != 2'd3) ? 3 : 2);
        exp_rd  = (exp_err || (we && size == 2'd3)) ? 0 : 1;
        exp_wr  = (exp_err || !we) ? 0 : ((size == 2'd3) ? 1 : 2);

        @(negedge clk);
        chk({tag, "_ready"}, 64'({req_ready, resp_valid}), 64'b10);
        chk({tag, "_hold"}, resp_rdata, last_rdata);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        for (int n = 1; n <= 8 && lat == 0; n++) begin
            @(negedge clk);
            if (memwb_ena) begin
                n_rd++;
                if (rd_cyc == 0) rd_cyc = n;
                if (mem_r_addr !== {3'b000, addr[63:3]}) addr_bad = 1'b1;
            end
            if (datamem_ena) begin
                n_wr++;
                if (wr_cyc == 0) wr_cyc = n;
                if (mem_w_addr !== {3'b000, addr[63:3]}) addr_bad = 1'b1;
            end
            if (req_ready) busy_bad = 1'b1;
            if (resp_valid) begin
                lat = n;
                got_err = resp_err;
                got_rdata = resp_rdata;
                req_valid = 1'b0;
            end else begin
                // Requests offered while busy must be ignored.
                req_valid = 1'($urandom_range(0, 1));
                req_we = 1'($urandom_range(0, 1));
                req_size = 2'($urandom_range(0, 3));
                req_addr = {$urandom(), $urandom()};
                req_wdata = {$urandom(), $urandom()};
            end
        end
        req_valid = 1'b0;
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_err"}, 64'(got_err), 64'(exp_err));
        chk({tag, "_rdata"}, got_rdata, exp_rdata);
        chk({tag, "_rdcyc"}, 64'(rd_cyc), 64'(exp_rd));
        chk({tag, "_wrcyc"}, 64'(wr_cyc), 64'(exp_wr));
        chk({tag, "_nacc"}, 64'(n_rd + n_wr), 64'((exp_rd != 0) + (exp_wr != 0)));
        chk({tag, "_addr"}, 64'(addr_bad), 64'h0);
        chk({tag, "_busy"}, 64'(busy_bad), 64'h0);
        if (we && !exp_err) ref_store(addr, size, wdata);
        last_rdata = exp_rdata;
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        exp_err;
        logic [63:0] exp_rdata;
    } vec_t;

    vec_t vecs [17];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 2'd3, 1'b0, 64'h10,  64'h8877665544332211, 1'b0, 64'h0};
        vecs[1]  = '{1'b0, 2'd0, 1'b0, 64'h17,  64'h0, 1'b0, 64'hFFFFFFFFFFFFFF88};
        vecs[2]  = '{1'b0, 2'd0, 1'b1, 64'h17,  64'h0, 1'b0, 64'h0000000000000088};
        vecs[3]  = '{1'b0, 2'd2, 1'b0, 64'h14,  64'h0, 1'b0, 64'hFFFFFFFF88776655};
        vecs[4]  = '{1'b0, 2'd3, 1'b0, 64'h10,  64'h0, 1'b0, 64'h8877665544332211};
        vecs[5]  = '{1'b1, 2'd1, 1'b0, 64'h12,  64'h123456789ABCABCD, 1'b0, 64'h0};
        vecs[6]  = '{1'b0, 2'd3, 1'b0, 64'h10,  64'h0, 1'b0, 64'h88776655ABCD2211};
        vecs[7]  = '{1'b0, 2'd1, 1'b0, 64'h12,  64'h0, 1'b0, 64'hFFFFFFFFFFFFABCD};
        vecs[8]  = '{1'b1, 2'd3, 1'b0, 64'h1F8, 64'hDEADBEEFCAFEF00D, 1'b0, 64'h0};
        vecs[9]  = '{1'b0, 2'd3, 1'b0, 64'h1F8, 64'h0, 1'b0, 64'hDEADBEEFCAFEF00D};
        vecs[10] = '{1'b0, 2'd2, 1'b0, 64'h12,  64'h0, 1'b1, 64'h0};
        vecs[11] = '{1'b1, 2'd0, 1'b0, 64'h200, 64'hFF, 1'b1, 64'h0};
        vecs[12] = '{1'b0, 2'd3, 1'b0, 64'h10,  64'h0, 1'b0, 64'h88776655ABCD2211};
        vecs[13] = '{1'b0, 2'd1, 1'b1, 64'h16,  64'h0, 1'b0, 64'h0000000000008877};
        vecs[14] = '{1'b0, 2'd2, 1'b1, 64'h14,  64'h0, 1'b0, 64'h0000000088776655};
        vecs[15] = '{1'b1, 2'd0, 1'b0, 64'h13,  64'hFFFFFFFFFFFFFF7E, 1'b0, 64'h0};
        vecs[16] = '{1'b0, 2'd2, 1'b0, 64'h10,  64'h0, 1'b0, 64'h000000007ECD2211};

        // Power-on reset
        repeat (2) @(negedge clk);
        chk("rst_ctrl", 64'({req_ready, resp_valid, resp_err, datamem_ena, memwb_ena}), 64'h0);
        chk("rst_rdata", resp_rdata, 64'h0);
        chk("rst_bus", mem_r_addr | mem_w_addr | mem_w_data, 64'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_release_ready", 64'(req_ready), 64'h1);

        // Fill every word through the DUT with dword stores
        for (int w = 0; w < 64; w++)
            do_op(1'b1, 2'd3, 1'b0, 64'(w * 8), {$urandom(), $urandom()}, 1'b0, 64'h0,
                  $sformatf("pre%0d", w));

        for (int i = 0; i < 17; i++)
            do_op(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                  vecs[i].exp_err, vecs[i].exp_rdata, $sformatf("vec%0d", i));

        // Reset during the write phase of a byte store to word 1
        begin
            bit seen = 1'b0;
            @(negedge clk);
            req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
            req_addr = 64'h8; req_wdata = 64'h5A;
            @(posedge clk);
            #1 req_valid = 1'b0;
            for (int n = 0; n < 6 && !seen; n++) begin
                @(negedge clk);
                if (datamem_ena) seen = 1'b1;
            end
            chk("mid_rst_wr_reached", 64'(seen), 64'h1);
            rst = 1'b1;
            #1;
            chk("mid_rst_ctrl", 64'({req_ready, resp_valid, resp_err, datamem_ena, memwb_ena}), 64'h0);
            chk("mid_rst_bus", mem_r_addr | mem_w_addr | mem_w_data | resp_rdata, 64'h0);
            @(negedge clk);
            chk("mid_rst_hold", 64'({req_ready, resp_valid, datamem_ena, memwb_ena}), 64'h0);
            rst = 1'b0;
            @(negedge clk);
            chk("mid_rst_release", 64'({req_ready, resp_valid}), 64'b10);
            last_rdata = 64'h0;
        end
        do_op(1'b0, 2'd3, 1'b0, 64'h8, 64'h0, 1'b0, ref_load(64'h8, 2'd3, 1'b0), "mid_rst_word1");

        // Random request stream against the byte-array model
        for (int i = 0; i < 300; i++) begin
            logic        we;
            logic [1:0]  size;
            logic        uns;
            logic [63:0] addr;
            logic [63:0] wdata;
            logic        e;
            int          r;
            we    = 1'($urandom_range(0, 1));
            size  = 2'($urandom_range(0, 3));
            uns   = 1'($urandom_range(0, 1));
            wdata = {$urandom(), $urandom()};
            r     = int'($urandom_range(0, 9));
            if (r == 0) begin
                addr = {$urandom(), $urandom()} | 64'h0000_0100_0000_0000;
            end else begin
                addr = 64'($urandom_range(0, 511));
                if (r < 8) addr = addr & ~64'((1 << size) - 1);
            end
            e = ref_err(addr, size);
            do_op(we, size, uns, addr, wdata, e,
                  (we || e) ? 64'h0 : ref_load(addr, size, uns), $sformatf("rnd%0d", i));
        end

        @(negedge clk);
        for (int w = 0; w < 64; w++)
            chk($sformatf("mem%0d", w), mem[w], ref_load(64'(w * 8), 2'd3, 1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
